// File: rtl/motor_ctrl_nch.sv
// APB3 slave for NCH motor channels: shadowed PWM duty, H-bridge direction bits,
// x4 quadrature position counters and windowed velocity capture.
module motor_ctrl_nch #(
  parameter int NCH     = 2,
  parameter int PWM_W   = 19,
  parameter int PERIOD  = 500000,
  parameter int POS_W   = 16,
  parameter int VEL_WIN = 25000000
) (
  input  logic               PCLK,
  input  logic               PRESERN,
  input  logic               PSEL,
  input  logic               PENABLE,
  input  logic               PWRITE,
  input  logic [31:0]        PADDR,
  input  logic [31:0]        PWDATA,
  output logic [31:0]        PRDATA,
  output logic               PREADY,
  output logic               PSLVERR,
  output logic [NCH-1:0]     pwm,
  output logic [2*NCH-1:0]   dir_ab,
  input  logic [NCH-1:0]     enc_a,
  input  logic [NCH-1:0]     enc_b
);

  localparam int               WIN_W    = (VEL_WIN > 1) ? $clog2(VEL_WIN) : 1;
  localparam logic [PWM_W-1:0] CNT_LAST = PWM_W'(PERIOD - 1);
  localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(VEL_WIN - 1);
  localparam logic [3:0]       NCH_L    = 4'(NCH);

  localparam logic [7:0] OFF_CTRL = 8'h00;
  localparam logic [7:0] OFF_DIR  = 8'h04;
  localparam logic [7:0] OFF_STAT = 8'h0C;
  localparam logic [3:0] SUB_DUTY = 4'h0;
  localparam logic [3:0] SUB_POS  = 4'h4;
  localparam logic [3:0] SUB_VEL  = 4'h8;

  // ---------------------------------------------------------------- decode
  logic [7:0] off;
  logic [3:0] grp, sub, ch;
  logic       ch_ok, sub_rw, map_wr, map_rd, wr_en;
  logic       wr_ctrl, wr_dir, wr_stat;

  assign off    = PADDR[7:0];
  assign grp    = off[7:4];
  assign sub    = off[3:0];
  assign ch     = grp - 4'd2;
  assign ch_ok  = (grp >= 4'd2) && (ch < NCH_L);
  assign sub_rw = ch_ok && ((sub == SUB_DUTY) || (sub == SUB_POS));
  assign map_wr = (off == OFF_CTRL) || (off == OFF_DIR) || (off == OFF_STAT) || sub_rw;
  assign map_rd = map_wr || (ch_ok && (sub == SUB_VEL));

  assign PREADY  = 1'b1;
  assign PSLVERR = PSEL & PENABLE & (PWRITE ? ~map_wr : ~map_rd);

  assign wr_en   = PSEL & PENABLE & PWRITE & map_wr;
  assign wr_ctrl = wr_en & (off == OFF_CTRL);
  assign wr_dir  = wr_en & (off == OFF_DIR);
  assign wr_stat = wr_en & (off == OFF_STAT);

  logic unused_bits;
  assign unused_bits = ^{PADDR[31:8], PWDATA};

  // ------------------------------------------------------- shared registers
  logic [NCH-1:0]   en, stat, ill, stat_clr;
  logic [2*NCH-1:0] dir;
  logic [PWM_W-1:0] cnt;
  logic [WIN_W-1:0] win;
  logic             period_end, win_end;

  assign period_end = (cnt == CNT_LAST);
  assign win_end    = (win == WIN_LAST);
  assign stat_clr   = wr_stat ? PWDATA[NCH-1:0] : '0;
  assign dir_ab     = dir;

  always_ff @(posedge PCLK or negedge PRESERN) begin
    if (!PRESERN) begin
      en   <= '0;
      dir  <= '0;
      stat <= '0;
      cnt  <= '0;
      win  <= '0;
    end else begin
      if (wr_ctrl) en  <= PWDATA[NCH-1:0];
      if (wr_dir)  dir <= PWDATA[2*NCH-1:0];
      // a new illegal transition outranks a simultaneous W1C clear
      stat <= (stat & ~stat_clr) | ill;
      cnt  <= period_end ? '0 : cnt + PWM_W'(1);
      win  <= win_end    ? '0 : win + WIN_W'(1);
    end
  end

  // encoder synchronisers and previous-state registers
  logic [NCH-1:0] a_s1, a_s2, b_s1, b_s2, a_prev, b_prev;

  always_ff @(posedge PCLK or negedge PRESERN) begin
    if (!PRESERN) begin
      a_s1   <= '0;
      a_s2   <= '0;
      b_s1   <= '0;
      b_s2   <= '0;
      a_prev <= '0;
      b_prev <= '0;
    end else begin
      a_s1   <= enc_a;
      a_s2   <= a_s1;
      b_s1   <= enc_b;
      b_s2   <= b_s1;
      a_prev <= a_s2;
      b_prev <= b_s2;
    end
  end

  // ----------------------------------------------------------- per channel
  logic [NCH-1:0][PWM_W-1:0] duty_v;
  logic [NCH-1:0][POS_W-1:0] pos_v, vel_v;

  for (genvar n = 0; n < NCH; n++) begin : g_ch
    logic [1:0]       cur, prv;
    logic             inc, dec, wr_duty, wr_pos, pwm_q;
    logic [PWM_W-1:0] shadow, active;
    logic [POS_W-1:0] pos, snap, vel;

    assign cur     = {a_s2[n], b_s2[n]};
    assign prv     = {a_prev[n], b_prev[n]};
    assign ill[n]  = ((prv ^ cur) == 2'b11);
    assign wr_duty = wr_en & ch_ok & (ch == 4'(n)) & (sub == SUB_DUTY);
    assign wr_pos  = wr_en & ch_ok & (ch == 4'(n)) & (sub == SUB_POS);

    always_comb begin
      inc = 1'b0;
      dec = 1'b0;
      case ({prv, cur})
        4'b00_01, 4'b01_11, 4'b11_10, 4'b10_00: inc = 1'b1;
        4'b01_00, 4'b11_01, 4'b10_11, 4'b00_10: dec = 1'b1;
        default: ;
      endcase
    end

    always_ff @(posedge PCLK or negedge PRESERN) begin
      if (!PRESERN) begin
        shadow <= '0;
        active <= '0;
        pwm_q  <= 1'b0;
        pos    <= '0;
        snap   <= '0;
        vel    <= '0;
      end else begin
        if (wr_duty)    shadow <= PWDATA[PWM_W-1:0];
        if (period_end) active <= shadow;
        pwm_q <= en[n] & (cnt < active);
        // a bus preset discards any encoder step in the same cycle
        if (wr_pos)   pos <= PWDATA[POS_W-1:0];
        else if (inc) pos <= pos + POS_W'(1);
        else if (dec) pos <= pos - POS_W'(1);
        if (wr_pos)       snap <= PWDATA[POS_W-1:0];
        else if (win_end) snap <= pos;
        if (win_end) vel <= pos - snap;
      end
    end

    assign pwm[n]    = pwm_q;
    assign duty_v[n] = shadow;
    assign pos_v[n]  = pos;
    assign vel_v[n]  = vel;
  end

  // ------------------------------------------------------------ read mux
  always_comb begin
    PRDATA = '0;
    if (PSEL && !PWRITE) begin
      case (off)
        OFF_CTRL: PRDATA = 32'(en);
        OFF_DIR:  PRDATA = 32'(dir);
        OFF_STAT: PRDATA = 32'(stat);
        default: begin
          for (int unsigned n = 0; n < NCH; n++) begin
            if (ch_ok && (ch == 4'(n))) begin
              case (sub)
                SUB_DUTY: PRDATA = 32'(duty_v[n]);
                SUB_POS:  PRDATA = 32'(pos_v[n]);
                SUB_VEL:  PRDATA = 32'(vel_v[n]);
                default:  ;
              endcase
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_motor_ctrl_nch.sv
// Directed bench for motor_ctrl_nch with a shortened PWM period and velocity window.
module tb_motor_ctrl_nch;
  localparam int NCH     = 2;
  localparam int PWM_W   = 19;
  localparam int PERIOD  = 500;
  localparam int POS_W   = 16;
  localparam int VEL_WIN = 400;

  logic             PCLK = 1'b0;
  logic             PRESERN = 1'b0;
  logic             PSEL = 1'b0, PENABLE = 1'b0, PWRITE = 1'b0;
  logic [31:0]      PADDR = '0, PWDATA = '0;
  logic [31:0]      PRDATA;
  logic             PREADY, PSLVERR;
  logic [NCH-1:0]   pwm;
  logic [2*NCH-1:0] dir_ab;
  logic [NCH-1:0]   enc_a = '0, enc_b = '0;

  motor_ctrl_nch #(
    .NCH(NCH), .PWM_W(PWM_W), .PERIOD(PERIOD), .POS_W(POS_W), .VEL_WIN(VEL_WIN)
  ) dut (
    .PCLK(PCLK), .PRESERN(PRESERN), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
    .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR),
    .pwm(pwm), .dir_ab(dir_ab), .enc_a(enc_a), .enc_b(enc_b)
  );

  always #5 PCLK = ~PCLK;

  int n_cmp = 0, n_err = 0;
  int tb_cyc;
  int acc = 0, last_hi = 0, per_done = 0;
  int gidx [NCH];
  logic        err;
  logic [31:0] rd;

  // clock edges since reset release; equals the ideal PWM/window counter phase
  always @(posedge PCLK or negedge PRESERN)
    if (!PRESERN) tb_cyc <= 0;
    else          tb_cyc <= tb_cyc + 1;

  // high-cycle count of pwm[0] over each ideal period (pwm lags cnt by one cycle)
  always @(negedge PCLK) begin
    if (PRESERN && tb_cyc > 0) begin
      if ((tb_cyc - 1) % PERIOD == 0) acc = 0;
      acc = acc + int'(pwm[0]);
      if ((tb_cyc - 1) % PERIOD == PERIOD - 1) begin
        last_hi  = acc;
        per_done = per_done + 1;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic apb_write(input logic [7:0] a, input logic [31:0] d, output logic e);
    @(posedge PCLK); #1;
    PSEL = 1'b1; PWRITE = 1'b1; PENABLE = 1'b0; PADDR = {24'h0, a}; PWDATA = d;
    @(posedge PCLK); #1;
    PENABLE = 1'b1;
    #1 e = PSLVERR;
    @(posedge PCLK); #1;
    PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
  endtask

  task automatic apb_read(input logic [7:0] a, output logic [31:0] d, output logic e);
    @(posedge PCLK); #1;
    PSEL = 1'b1; PWRITE = 1'b0; PENABLE = 1'b0; PADDR = {24'h0, a};
    @(posedge PCLK); #1;
    PENABLE = 1'b1;
    #1 begin d = PRDATA; e = PSLVERR; end
    @(posedge PCLK); #1;
    PSEL = 1'b0; PENABLE = 1'b0;
  endtask

  task automatic wr(input logic [7:0] a, input logic [31:0] d);
    logic e;
    apb_write(a, d, e);
  endtask

  task automatic rd_check(input string tag, input logic [7:0] a, input logic [31:0] exp);
    logic [31:0] d;
    logic e;
    apb_read(a, d, e);
    check(tag, d, exp);
  endtask

  task automatic wait_mod(input string tag, input int m, input int r);
    bit found = 1'b0;
    for (int k = 0; k < m + 5; k++) begin
      @(posedge PCLK); #1;
      if (tb_cyc % m == r) begin found = 1'b1; break; end
    end
    check(tag, 32'(found), 32'd1);
  endtask

  task automatic wait_period(input string tag);
    int start = per_done;
    bit found = 1'b0;
    for (int k = 0; k < PERIOD + 10; k++) begin
      @(posedge PCLK); #1;
      if (per_done != start) begin found = 1'b1; break; end
    end
    if (!found) check(tag, 32'd0, 32'd1);
  endtask

  function automatic logic [1:0] gray(input int i);
    case (i & 3)
      0: gray = 2'b00;
      1: gray = 2'b01;
      2: gray = 2'b11;
      default: gray = 2'b10;
    endcase
  endfunction

  // d=+1/-1 is a legal step; d=2 flips both pins at once
  task automatic enc_move(input int c, input int d);
    logic [1:0] s;
    @(posedge PCLK); #1;
    gidx[c] = (gidx[c] + d) & 3;
    s = gray(gidx[c]);
    enc_a[c] = s[1];
    enc_b[c] = s[0];
  endtask

  initial begin
    for (int i = 0; i < NCH; i++) gidx[i] = 0;

    // ---- T1 reset
    repeat (3) @(posedge PCLK);
    #1 PRESERN = 1'b1;
    wr(8'h20, 32'd400);
    wr(8'h00, 32'd1);
    wr(8'h04, 32'd5);
    wait_period("t1_wp");
    wait_period("t1_wp");
    wait_mod("t1_mid_to", PERIOD, 200);
    check("t1_pre_pwm", 32'(pwm), 32'h1);
    check("t1_pre_dir", 32'(dir_ab), 32'h5);
    PRESERN = 1'b0;
    #1;
    check("t1_rst_pwm", 32'(pwm), 32'h0);
    check("t1_rst_dir", 32'(dir_ab), 32'h0);
    PSEL = 1'b1; PWRITE = 1'b0; PADDR = 32'h20;
    #1 check("t1_rst_rd", PRDATA, 32'h0);
    repeat (3) @(posedge PCLK);
    #1 PRESERN = 1'b1;
    PSEL = 1'b0;
    rd_check("t1_ctrl", 8'h00, 32'h0);
    rd_check("t1_dir",  8'h04, 32'h0);
    rd_check("t1_duty", 8'h20, 32'h0);
    rd_check("t1_pos",  8'h24, 32'h0);
    rd_check("t1_stat", 8'h0C, 32'h0);
    check("t1_pready", 32'(PREADY), 32'h1);

    // first rise must land on the sample of cnt==0 if cnt restarted at 0
    wr(8'h20, 32'd250);
    wr(8'h00, 32'd1);
    begin
      bit rose = 1'b0;
      for (int k = 0; k < 3 * PERIOD; k++) begin
        @(posedge PCLK); #1;
        if (pwm[0]) begin rose = 1'b1; break; end
      end
      check("t1_rose", 32'(rose), 32'd1);
      check("t1_restart_phase", 32'(tb_cyc % PERIOD), 32'd1);
    end

    // ---- T2 PWM duty
    wait_period("t2_wp");
    wait_period("t2_wp");
    check("t2_duty_half", 32'(last_hi), 32'd250);
    rd_check("t2_duty_rd", 8'h20, 32'd250);
    wr(8'h20, 32'd0);
    wait_period("t2_wp");
    wait_period("t2_wp");
    check("t2_duty_zero", 32'(last_hi), 32'd0);
    wr(8'h20, 32'd600);
    wait_period("t2_wp");
    wait_period("t2_wp");
    check("t2_duty_over", 32'(last_hi), 32'd500);
    wr(8'h00, 32'd0);
    check("t2_en_lag", 32'(pwm[0]), 32'd1);
    @(posedge PCLK); #1;
    check("t2_en_off", 32'(pwm[0]), 32'd0);
    wr(8'h00, 32'd1);
    wr(8'h20, 32'd250);
    wait_period("t2_wp");
    wait_period("t2_wp");
    check("t2_duty_back", 32'(last_hi), 32'd250);

    // ---- T3 shadowed duty
    wait_mod("t3_sync_to", PERIOD, 150);
    wr(8'h20, 32'd100);
    wait_period("t3_wp");
    check("t3_cur_period", 32'(last_hi), 32'd250);
    wait_period("t3_wp");
    check("t3_next_period", 32'(last_hi), 32'd100);

    // ---- T4 encoder ch1
    for (int i = 0; i < 7; i++) begin
      enc_move(1, 1);
      repeat (4) @(posedge PCLK);
    end
    enc_move(1, 1);
    PSEL = 1'b1; PWRITE = 1'b0; PENABLE = 1'b0; PADDR = 32'h34;
    @(posedge PCLK); #1;
    @(posedge PCLK); #1;
    check("t4_pos_lat2", PRDATA, 32'd7);
    @(posedge PCLK); #1;
    check("t4_pos_lat3", PRDATA, 32'd8);
    PSEL = 1'b0;
    for (int i = 0; i < 3; i++) begin
      enc_move(1, -1);
      repeat (4) @(posedge PCLK);
    end
    rd_check("t4_pos_rev", 8'h34, 32'd5);
    enc_move(1, 2);
    repeat (5) @(posedge PCLK);
    rd_check("t4_pos_ill", 8'h34, 32'd5);
    rd_check("t4_stat_set", 8'h0C, 32'h2);
    wr(8'h0C, 32'h1);
    rd_check("t4_stat_keep", 8'h0C, 32'h2);
    wr(8'h0C, 32'h2);
    rd_check("t4_stat_clr", 8'h0C, 32'h0);

    // ---- T5 wrap and velocity ch0
    wait_mod("t5_sync_to", VEL_WIN, 10);
    wr(8'h24, 32'h7FFE);
    for (int i = 0; i < 4; i++) begin
      enc_move(0, 1);
      repeat (5) @(posedge PCLK);
    end
    rd_check("t5_pos_wrap", 8'h24, 32'h8002);
    wait_mod("t5_win_to", VEL_WIN, 1);
    rd_check("t5_vel", 8'h28, 32'd4);
    wait_mod("t5_win2_to", VEL_WIN, 1);
    rd_check("t5_vel_idle", 8'h28, 32'd0);

    // ---- T6 bus errors
    apb_read(8'h50, rd, err);
    check("t6_unmap_err", 32'(err), 32'd1);
    check("t6_unmap_rd", rd, 32'h0);
    apb_write(8'h28, 32'h55, err);
    check("t6_velwr_err", 32'(err), 32'd1);
    apb_read(8'h28, rd, err);
    check("t6_vel_keep", rd, 32'h0);
    check("t6_vel_ok", 32'(err), 32'd0);
    apb_write(8'h04, 32'hA, err);
    check("t6_dir_err", 32'(err), 32'd0);
    check("t6_dir_pins", 32'(dir_ab), 32'hA);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
